i2c_reg_ctrl: RTL and testbench

I2C_REG_CTRL -- requirements
Module: i2c_reg_ctrl

---
 rtl/i2c_reg_ctrl.sv | 82 ++++++++
 tb/tb_i2c_reg_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_ctrl.sv
// Byte-oriented register file behind an I2C target: the first byte of a write
// sets the register pointer, further bytes write and auto-increment; reads stream from the pointer.
module i2c_reg_ctrl #(
    parameter int         NUM_REGS    = 8,
    parameter logic [7:0] RESET_VALUE = 8'h00
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 rx_byte_data_i,
    input  logic                       rx_byte_valid_i,
    input  logic                       i2c_stop_i,
    input  logic                       tx_req_i,
    output logic [7:0]                 tx_byte_data_o,
    output logic                       tx_byte_valid_o,
    output logic [8*NUM_REGS-1:0]      regs_o,
    output logic                       wr_strobe_o,
    output logic [$clog2(NUM_REGS)-1:0] wr_addr_o,
    output logic [$clog2(NUM_REGS)-1:0] ptr_o
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    typedef enum logic {
        ST_ADDR = 1'b0,
        ST_DATA = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic              pending;
    logic [7:0]        regs [NUM_REGS];

    logic              rx_wr;
    logic [ADDR_W-1:0] ptr_rx;
    logic              rd_go;
    logic [7:0]        rd_data;

    // The received byte is always applied first; any read this cycle then
    // works from the pointer and contents as left by that byte.
    always_comb begin
        rx_wr   = rx_byte_valid_i && (state == ST_DATA);
        ptr_rx  = ptr;
        if (rx_byte_valid_i) begin
            if (state == ST_ADDR) ptr_rx = rx_byte_data_i[ADDR_W-1:0];
            else                  ptr_rx = ptr + ADDR_W'(1);
        end
        // A fresh request colliding with an rx byte is deferred to pending.
        rd_go   = pending || (tx_req_i && !rx_byte_valid_i);
        rd_data = (rx_wr && (ptr == ptr_rx)) ? rx_byte_data_i : regs[ptr_rx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_ADDR;
            ptr             <= '0;
            pending         <= 1'b0;
            tx_byte_data_o  <= 8'h00;
            tx_byte_valid_o <= 1'b0;
            wr_strobe_o     <= 1'b0;
            wr_addr_o       <= '0;
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= RESET_VALUE;
        end else begin
            wr_strobe_o     <= rx_wr;
            tx_byte_valid_o <= rd_go;
            if (rx_wr) begin
                regs[ptr] <= rx_byte_data_i;
                wr_addr_o <= ptr;
            end
            if (rd_go) tx_byte_data_o <= rd_data;
            ptr <= rd_go ? ptr_rx + ADDR_W'(1) : ptr_rx;
            // One-deep: a request arriving while one is pending is dropped.
            pending <= !pending && tx_req_i && rx_byte_valid_i;
            if (i2c_stop_i)           state <= ST_ADDR;
            else if (rx_byte_valid_i) state <= ST_DATA;
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign regs_o[8*k +: 8] = regs[k];
    end

    assign ptr_o = ptr;
endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Scoreboard bench for i2c_reg_ctrl: a behavioural model predicts writes,
// read bytes and register state; a monitor compares them as the DUT presents them.
module tb_i2c_reg_ctrl;
    localparam int         N  = 8;
    localparam logic [7:0] RV = 8'hA5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   rx_byte_data_i = 8'h00;
    logic         rx_byte_valid_i = 1'b0;
    logic         i2c_stop_i = 1'b0;
    logic         tx_req_i = 1'b0;
    logic [7:0]   tx_byte_data_o;
    logic         tx_byte_valid_o;
    logic [8*N-1:0] regs_o;
    logic         wr_strobe_o;
    logic [2:0]   wr_addr_o;
    logic [2:0]   ptr_o;

    i2c_reg_ctrl #(.NUM_REGS(N), .RESET_VALUE(RV)) dut (
        .clk(clk), .rst(rst),
        .rx_byte_data_i(rx_byte_data_i), .rx_byte_valid_i(rx_byte_valid_i),
        .i2c_stop_i(i2c_stop_i), .tx_req_i(tx_req_i),
        .tx_byte_data_o(tx_byte_data_o), .tx_byte_valid_o(tx_byte_valid_o),
        .regs_o(regs_o), .wr_strobe_o(wr_strobe_o), .wr_addr_o(wr_addr_o),
        .ptr_o(ptr_o)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; int addr; logic [7:0] data; } ev_t;
    typedef struct { int cyc; bit rst; logic [63:0] regs; int ptr; logic [7:0] last_tx; } snap_t;

    ev_t   wr_q[$];
    ev_t   tx_q[$];
    snap_t snap_q[$];

    // Reference model state
    logic [7:0] mem [N];
    int         mptr = 0;
    bit         in_data = 0;
    bit         pend = 0;
    logic [7:0] last_tx = 8'h00;
    int         cyc = 0;

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one cycle of inputs and advance the model by the same edge.
    task automatic step(input bit r, input logic [7:0] d, input bit s, input bit t, input bit x);
        snap_t sn;
        bit    rd_now;
        bit    new_pend;
        @(negedge clk);
        rx_byte_valid_i = r; rx_byte_data_i = d; i2c_stop_i = s; tx_req_i = t; rst = x;
        if (x) begin
            for (int k = 0; k < N; k++) mem[k] = RV;
            mptr = 0; in_data = 0; pend = 0; last_tx = 8'h00;
        end else begin
            rd_now   = pend || (t && !r);
            new_pend = !pend && t && r;
            if (r) begin
                if (in_data) begin
                    wr_q.push_back('{cyc: cyc, addr: mptr, data: d});
                    mem[mptr] = d;
                    mptr = (mptr + 1) % N;
                end else begin
                    mptr = d % N;
                    in_data = 1;
                end
            end
            if (rd_now) begin
                last_tx = mem[mptr];
                tx_q.push_back('{cyc: cyc, addr: mptr, data: mem[mptr]});
                mptr = (mptr + 1) % N;
            end
            pend = new_pend;
            if (s) in_data = 0;
        end
        sn.cyc = cyc; sn.rst = x; sn.ptr = mptr; sn.last_tx = last_tx; sn.regs = '0;
        for (int k = 0; k < N; k++) sn.regs[8*k +: 8] = mem[k];
        snap_q.push_back(sn);
        cyc++;
    endtask

    task automatic rx(input logic [7:0] d);  step(1, d, 0, 0, 0); endtask
    task automatic idle();                   step(0, 8'h00, 0, 0, 0); endtask
    task automatic stop();                   step(0, 8'h00, 1, 0, 0); endtask
    task automatic txr();                    step(0, 8'h00, 0, 1, 0); endtask
    task automatic reset1();                 step(0, 8'h00, 0, 0, 1); endtask

    // Monitor: checks the edge driven in the previous half cycle.
    snap_t sm;
    ev_t   ev;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (snap_q.size() > 0) begin
                sm = snap_q.pop_front();
                chk("regs", {{(64-8*N){1'b0}}, regs_o}, sm.regs);
                chk("ptr", {61'd0, ptr_o}, 64'(sm.ptr));
                chk("tx_data_hold", {56'd0, tx_byte_data_o}, {56'd0, sm.last_tx});
                if (sm.rst) begin
                    chk("rst_wr_strobe", {63'd0, wr_strobe_o}, 64'd0);
                    chk("rst_tx_valid", {63'd0, tx_byte_valid_o}, 64'd0);
                    chk("rst_wr_addr", {61'd0, wr_addr_o}, 64'd0);
                end
                if (wr_strobe_o) begin
                    if (wr_q.size() == 0) chk("wr_unexpected", 64'd1, 64'd0);
                    else begin
                        ev = wr_q.pop_front();
                        chk("wr_cycle", 64'(sm.cyc), 64'(ev.cyc));
                        chk("wr_addr", {61'd0, wr_addr_o}, 64'(ev.addr));
                        chk("wr_data", {56'd0, regs_o[8*wr_addr_o +: 8]}, {56'd0, ev.data});
                    end
                end else if (wr_q.size() > 0 && wr_q[0].cyc <= sm.cyc) begin
                    ev = wr_q.pop_front();
                    chk("wr_missing", 64'd0, 64'd1);
                end
                if (tx_byte_valid_o) begin
                    if (tx_q.size() == 0) chk("tx_unexpected", 64'd1, 64'd0);
                    else begin
                        ev = tx_q.pop_front();
                        chk("tx_cycle", 64'(sm.cyc), 64'(ev.cyc));
                        chk("tx_data", {56'd0, tx_byte_data_o}, {56'd0, ev.data});
                    end
                end else if (tx_q.size() > 0 && tx_q[0].cyc <= sm.cyc) begin
                    ev = tx_q.pop_front();
                    chk("tx_missing", 64'd0, 64'd1);
                end
            end
        end
    end

    initial begin
        int wait_cnt;
        reset1(); reset1(); idle();
        // write burst then stop
        rx(8'h02); rx(8'hAA); rx(8'hBB); stop(); idle();
        // wrap across the top register
        rx(8'h07); rx(8'h11); rx(8'h22); stop();
        // read-back with wrap
        rx(8'h06); stop(); txr(); txr(); idle(); txr(); idle(); idle();
        // upper pointer bits ignored
        rx(8'hF3); rx(8'h5C); stop();
        // rx/tx collision in DATA with ptr 4
        rx(8'h03); rx(8'h10); step(1, 8'h99, 0, 1, 0); idle(); idle(); stop();
        // rx and stop together, next byte is a pointer
        rx(8'h01); step(1, 8'h77, 1, 0, 0); rx(8'h02); rx(8'h3C); stop();
        // request while pending is dropped
        rx(8'h05); rx(8'h66); step(1, 8'h67, 0, 1, 0); txr(); idle(); idle(); stop();
        // reset mid-burst
        rx(8'h01); rx(8'h33); reset1(); rx(8'h44); idle(); stop();
        // randomized traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(2, 0) == 0, 8'($urandom()),
                 $urandom_range(7, 0) == 0, $urandom_range(3, 0) == 0,
                 $urandom_range(149, 0) == 0);
        end
        idle(); idle(); idle();
        wait_cnt = 0;
        while (snap_q.size() > 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        #2;
        chk("monitor_drained", 64'(snap_q.size()), 64'd0);
        chk("wr_q_empty", 64'(wr_q.size()), 64'd0);
        chk("tx_q_empty", 64'(tx_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
